hit_scorer: RTL
===============

// Module: hit_scorer
// PURPOSE
//   Judges player key presses against the lit mole and keeps the game tally.
//   Sits downstream of keypad_controller (key_valid/key) and light_controller (light_on/light_pos).
//   Produces score, miss count, lives and game_over for the top-level FSM and the HEX decoders.
//   Replaces the combinational total_points logic in the top level.
// PARAMETERS
//   SCORE_W    6   width of score/misses/streak counters
//   MAX_SCORE  63  saturation value for score, misses and streak (must be <= 2**SCORE_W-1)
//   LIVES_INIT 3   lives loaded at reset (2-bit counter)
//   NUM_KEYS   9   valid key codes are 0..NUM_KEYS-1; higher codes are ignored
// PORTS
//   clk         in   1        system clock (CLOCK_50 at top)
//   reset       in   1        asynchronous, active-high reset
//   enable      in   1        high while the top FSM is in PLAY
//   use_lives   in   1        lives mode selected (SW game mode 0010)
//   key_valid   in   1        level: keypad holds a debounced key
//   key         in   4        key code, meaningful while key_valid=1
//   light_on    in   1        level: a light is currently lit
//   light_pos   in   4        index of the lit light, stable while light_on=1
//   score       out  SCORE_W  hits, saturating
//   misses      out  SCORE_W  wrong keys plus timeouts, saturating
//   lives_left  out  2        remaining lives
//   hit_pulse   out  1        1-cycle strobe per hit
//   miss_pulse  out  1        1-cycle strobe per miss
//   game_over   out  1        sticky; high once lives reach 0 in lives mode
// BEHAVIOUR
//   Reset: state IDLE, score=0, misses=0, lives_left=LIVES_INIT, all pulses=0, game_over=0.
//   Edges: key_evt = key_valid & ~key_valid_q; lit_rise/lit_fall likewise on light_on (registered _q).
//     One key_evt per press regardless of hold length. key_evt with key>=NUM_KEYS is discarded.
//   Latency: counters and pulses update on the clk edge after the cycle in which key_evt/lit_fall is true.
//   FSM (registered, 2-bit):
//     IDLE : lit_rise & enable -> ARMED. key_evt ignored (no light = no penalty).
//     ARMED: key_evt & key==light_pos -> score+1, hit_pulse, DONE.
//            key_evt & key!=light_pos -> misses+1, miss_pulse, DONE.
//            lit_fall with no key_evt -> misses+1, miss_pulse (timeout), IDLE.
//            key_evt and lit_fall in the same cycle: judge the key (hit or wrong key); then go to IDLE.
//     DONE : further key_evt ignored; lit_fall -> IDLE. At most one judgement per light.
//     OVER : absorbing until reset; no counter changes, pulses 0.
//   Lives: each miss decrements lives_left only when use_lives=1; saturates at 0.
//     When lives_left would reach 0, the next state is OVER and game_over=1 on that same edge.
//   Saturation: score/misses hold at MAX_SCORE. A hit at MAX_SCORE still pulses hit_pulse.
//   enable=0: FSM is forced to IDLE (OVER is kept); counters hold; pulses 0.
//     Re-enable with light already lit does not arm until the next lit_rise.
//   reset asserted mid-window returns every output to its reset value immediately (async).
// CONFIGURATION
//   HIT_SCORER_STREAK_EN defined: adds outputs streak[SCORE_W] and best_streak[SCORE_W].
//     streak+1 on hit, cleared on any miss; best_streak = max(best_streak, streak).
//     A hit that makes streak a nonzero multiple of 5 adds +2 to score (saturating).
//     Reset clears both streak outputs.
//   Not defined: streak ports absent; every hit adds exactly +1.
// STRUCTURE
//   Shared package wam_pkg: SCORE_W, NUM_KEYS, LIVES_INIT, MAX_SCORE defaults; FSM encodings
//     HS_IDLE=0, HS_ARMED=1, HS_DONE=2, HS_OVER=3.
//   One sub-module, rise_detect (1-bit register plus rise/fall outputs, async active-high reset).
//     Instantiated for key_valid and for light_on.
//   Counters, lives and FSM stay in hit_scorer.
// TESTING
//   Matched hit: enable=1, light_on rises with light_pos=4, key_valid rises with key=4 and is held 20 cycles
//     -> score=1, one hit_pulse, misses=0.
//   Wrong key then timeout: light_pos=2, key=7, then light_on falls
//     -> misses=1 (not 2), one miss_pulse.
//   Timeout only: light_on high 100 cycles then low, no key
//     -> misses=1, miss_pulse on the edge after the fall.
//   Lives: use_lives=1, LIVES_INIT=3, three timeouts
//     -> lives_left 3,2,1,0; game_over=1 with the 3rd miss; a later matched key leaves score unchanged.
//   Same-cycle edge: key_evt matching light_pos in the cycle light_on falls
//     -> score+1, misses unchanged. Then 64 hits -> score holds at 63.
//   Async reset: reset pulsed while ARMED -> all outputs at reset values before the next clk edge.
//     With HIT_SCORER_STREAK_EN: 5 consecutive hits -> score=6, streak=5.

Source files
------------

// File: rtl/wam_pkg.sv
// Shared whack-a-mole definitions: counter widths, game limits, hit_scorer FSM encoding.
package wam_pkg;

    localparam int unsigned SCORE_W    = 6;
    localparam int unsigned MAX_SCORE  = 63;
    localparam int unsigned LIVES_INIT = 3;
    localparam int unsigned NUM_KEYS   = 9;
    localparam int unsigned KEY_W      = 4;
    localparam int unsigned LIVES_W    = 2;

    typedef enum logic [1:0] {
        HS_IDLE  = 2'd0,
        HS_ARMED = 2'd1,
        HS_DONE  = 2'd2,
        HS_OVER  = 2'd3
    } hs_state_e;

    typedef logic [SCORE_W-1:0] score_t;

    typedef struct packed {
        score_t             score;
        score_t             misses;
        logic [LIVES_W-1:0] lives;
    } hs_tally_t;

    // Add inc to a, holding at MAX_SCORE.
    function automatic score_t sat_add(score_t a, logic [1:0] inc);
        logic [SCORE_W:0] sum;
        sum = {1'b0, a} + (SCORE_W+1)'(inc);
        return (sum > (SCORE_W+1)'(MAX_SCORE)) ? score_t'(MAX_SCORE) : sum[SCORE_W-1:0];
    endfunction

endpackage

// File: rtl/hit_scorer_if.sv
// Bus between the game controllers and hit_scorer. Streak signals exist only when
// HIT_SCORER_STREAK_EN is defined.
interface hit_scorer_if;
    import wam_pkg::*;

    logic               enable;
    logic               use_lives;
    logic               key_valid;
    logic [KEY_W-1:0]   key;
    logic               light_on;
    logic [KEY_W-1:0]   light_pos;
    score_t             score;
    score_t             misses;
    logic [LIVES_W-1:0] lives_left;
    logic               hit_pulse;
    logic               miss_pulse;
    logic               game_over;
`ifdef HIT_SCORER_STREAK_EN
    score_t             streak;
    score_t             best_streak;
`endif

    modport master (
        output enable, use_lives, key_valid, key, light_on, light_pos,
        input  score, misses, lives_left, hit_pulse, miss_pulse, game_over
`ifdef HIT_SCORER_STREAK_EN
        , input streak, best_streak
`endif
    );

    modport slave (
        input  enable, use_lives, key_valid, key, light_on, light_pos,
        output score, misses, lives_left, hit_pulse, miss_pulse, game_over
`ifdef HIT_SCORER_STREAK_EN
        , output streak, best_streak
`endif
    );

endinterface

// File: rtl/hit_scorer_rise_detect.sv
// rise_detect: registers a level and flags its rising and falling edges.
module rise_detect (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic rise_c,
    output logic fall_c
);

    logic d_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) d_q <= 1'b0;
        else       d_q <= d;
    end

    assign rise_c = d & ~d_q;
    assign fall_c = ~d & d_q;

endmodule

// File: rtl/hit_scorer.sv
// hit_scorer: judges key presses against the lit mole and keeps score/misses/lives.
// Optional HIT_SCORER_STREAK_EN adds streak tracking with a bonus every 5th consecutive hit.
module hit_scorer
    import wam_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    hit_scorer_if.slave  bus
);

    logic      key_rise_c, key_fall_unused_c;
    logic      lit_rise_c, lit_fall_c;
    logic      key_evt_c;
    hs_state_e state_q, state_d;
    hs_tally_t tally_q, tally_d;
    logic      hit_d, miss_d;
    logic      hit_q, miss_q, over_q;
    logic [1:0] hit_inc;

    rise_detect u_key_edge (
        .clk(clk), .reset(reset), .d(bus.key_valid),
        .rise_c(key_rise_c), .fall_c(key_fall_unused_c)
    );

    rise_detect u_lit_edge (
        .clk(clk), .reset(reset), .d(bus.light_on),
        .rise_c(lit_rise_c), .fall_c(lit_fall_c)
    );

    // Out-of-range key codes never count as a press.
    assign key_evt_c = key_rise_c & (bus.key < KEY_W'(NUM_KEYS));

`ifdef HIT_SCORER_STREAK_EN
    score_t streak_q, streak_d, best_q, best_d;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= HS_IDLE;
            tally_q <= '{score: '0, misses: '0, lives: LIVES_W'(LIVES_INIT)};
            hit_q   <= 1'b0;
            miss_q  <= 1'b0;
            over_q  <= 1'b0;
`ifdef HIT_SCORER_STREAK_EN
            streak_q <= '0;
            best_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            tally_q <= tally_d;
            hit_q   <= hit_d;
            miss_q  <= miss_d;
            over_q  <= (state_d == HS_OVER);
`ifdef HIT_SCORER_STREAK_EN
            streak_q <= streak_d;
            best_q   <= best_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        tally_d = tally_q;
        hit_d   = 1'b0;
        miss_d  = 1'b0;
        hit_inc = 2'd1;
`ifdef HIT_SCORER_STREAK_EN
        streak_d = streak_q;
        best_d   = best_q;
`endif

        // One judgement per light; a disabled game drops back to IDLE unless already over.
        if (!bus.enable) begin
            if (state_q != HS_OVER) state_d = HS_IDLE;
        end else begin
            case (state_q)
                HS_IDLE:  if (lit_rise_c) state_d = HS_ARMED;
                HS_ARMED: begin
                    if (key_evt_c) begin
                        if (bus.key == bus.light_pos) hit_d  = 1'b1;
                        else                          miss_d = 1'b1;
                        state_d = lit_fall_c ? HS_IDLE : HS_DONE;
                    end else if (lit_fall_c) begin
                        miss_d  = 1'b1;
                        state_d = HS_IDLE;
                    end
                end
                HS_DONE:  if (lit_fall_c) state_d = HS_IDLE;
                HS_OVER:  state_d = HS_OVER;
                default:  state_d = HS_IDLE;
            endcase
        end

`ifdef HIT_SCORER_STREAK_EN
        if (hit_d) begin
            streak_d = sat_add(streak_q, 2'd1);
            if ((streak_d != '0) && ((streak_d % SCORE_W'(5)) == '0)) hit_inc = 2'd2;
        end
        if (miss_d) streak_d = '0;
        best_d = (streak_d > best_q) ? streak_d : best_q;
`endif

        if (hit_d) tally_d.score = sat_add(tally_q.score, hit_inc);

        // Losing the last life ends the game on the same edge as the miss.
        if (miss_d) begin
            tally_d.misses = sat_add(tally_q.misses, 2'd1);
            if (bus.use_lives) begin
                if (tally_q.lives <= LIVES_W'(1)) begin
                    tally_d.lives = '0;
                    state_d       = HS_OVER;
                end else begin
                    tally_d.lives = tally_q.lives - LIVES_W'(1);
                end
            end
        end
    end

    assign bus.score      = tally_q.score;
    assign bus.misses     = tally_q.misses;
    assign bus.lives_left = tally_q.lives;
    assign bus.hit_pulse  = hit_q;
    assign bus.miss_pulse = miss_q;
    assign bus.game_over  = over_q;
`ifdef HIT_SCORER_STREAK_EN
    assign bus.streak      = streak_q;
    assign bus.best_streak = best_q;
`endif

endmodule
